// File: rtl/bram_tile_sequencer.sv
// bram_tile_sequencer: copies one image tile from external pixel memory into
// the two bram18 banks using column-interleaved write addresses, then sweeps
// the shared read port and drives the sm_top_module select aligned to doutb.
module bram_tile_sequencer #(
  parameter int COLS       = 4,
  parameter int ROWS       = 12,
  parameter int BANK2_BASE = 50,
  parameter int RD_WORDS   = 12,
  parameter int EXT_AW     = 8,
  parameter int AW_A       = 11,
  parameter int AW_B       = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic [EXT_AW-1:0] ext_adr1,
  output logic [EXT_AW-1:0] ext_adr2,
  input  logic [7:0]        ext_dat1,
  input  logic [7:0]        ext_dat2,
  output logic              ena,
  output logic              wea1,
  output logic              wea2,
  output logic [AW_A-1:0]   addra,
  output logic [7:0]        dina1,
  output logic [7:0]        dina2,
  output logic              enb,
  output logic [AW_B-1:0]   addrb,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic              busy,
  output logic              complete
);

  localparam int CW = (COLS     > 1) ? $clog2(COLS)     : 1;
  localparam int RW = (ROWS     > 1) ? $clog2(ROWS)     : 1;
  localparam int KW = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(RD_WORDS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_LOAD_FLUSH = 3'd2;
  localparam logic [2:0] S_READ       = 3'd3;
  localparam logic [2:0] S_READ_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     c;
  logic [RW-1:0]     r;
  logic [KW-1:0]     k;

  // vld_pipe[0]: element issued to external memory (aligned with ext_adr)
  // vld_pipe[1]: data back from memory, write strobe to the banks
  logic [1:0]        vld_pipe;
  logic [AW_A-1:0]   waddr_q;

  logic [EXT_AW-1:0] elem_idx;
  logic [AW_A-1:0]   waddr_calc;

  // Source index walks the tile column by column; the bank address
  // interleaves columns so each row of the tile lands in consecutive words.
  assign elem_idx   = EXT_AW'(c) * EXT_AW'(ROWS) + EXT_AW'(r);
  assign waddr_calc = AW_A'(c) + AW_A'(COLS) * AW_A'(r);

  // Control FSM with column/row/read-word counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      c        <= '0;
      r        <= '0;
      k        <= '0;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            c        <= '0;
            r        <= '0;
            k        <= '0;
            busy     <= 1'b1;
            complete <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r == R_LAST) begin
            r <= '0;
            if (c == C_LAST) begin
              c     <= '0;
              state <= S_LOAD_FLUSH;
            end else begin
              c <= c + CW'(1);
            end
          end else begin
            r <= r + RW'(1);
          end
        end
        // last element is still in flight from external memory
        S_LOAD_FLUSH: state <= S_READ;
        S_READ: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_READ_FLUSH;
          end else begin
            k <= k + KW'(1);
          end
        end
        // wait for the final read enable to retire so complete follows
        // the last out_valid cycle
        S_READ_FLUSH: begin
          if (!enb) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            complete <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load datapath: issue address to external memory, then write one cycle later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ext_adr1 <= '0;
      ext_adr2 <= '0;
      waddr_q  <= '0;
      vld_pipe <= '0;
      addra    <= '0;
    end else begin
      if (state == S_LOAD) begin
        ext_adr1    <= elem_idx;
        ext_adr2    <= elem_idx + EXT_AW'(BANK2_BASE);
        waddr_q     <= waddr_calc;
        vld_pipe[0] <= 1'b1;
      end else begin
        ext_adr1    <= '0;
        ext_adr2    <= '0;
        waddr_q     <= '0;
        vld_pipe[0] <= 1'b0;
      end
      vld_pipe[1] <= vld_pipe[0];
      addra       <= vld_pipe[0] ? waddr_q : '0;
    end
  end

  assign ena  = vld_pipe[1];
  assign wea1 = vld_pipe[1];
  assign wea2 = vld_pipe[1];

  // External data arrives in the strobe cycle; pass it straight to the banks.
  assign dina1 = vld_pipe[1] ? ext_dat1 : 8'd0;
  assign dina2 = vld_pipe[1] ? ext_dat2 : 8'd0;

  // Read port sweep: one word per cycle while in READ.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      enb   <= 1'b0;
      addrb <= '0;
    end else if (state == S_READ) begin
      enb   <= 1'b1;
      addrb <= AW_B'(k);
    end else begin
      enb   <= 1'b0;
      addrb <= '0;
    end
  end

  // Delay valid/select by the one-cycle BRAM read latency so they line up with doutb.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      sel       <= 2'b00;
    end else begin
      out_valid <= enb;
      sel       <= enb ? addrb[1:0] : 2'b00;
    end
  end

endmodule
